feature_map_collector: RTL and testbench
========================================

// Module: feature_map_collector
// PURPOSE
//   Sink for the valid-only feature-map stream produced by the conv/maxpool pipeline
//   (16-bit signed samples qualified by a 1-cycle valid, no backpressure).
//   Captures one full frame (default 13x13 maxpool map) into an internal buffer.
//   Replays the frame to the next layer over a ready/valid handshake with a last marker.
//   Sits between the Conv_Max_Full output and the downstream dense/classifier stage.
// PARAMETERS
//   DATA_W  16   sample width, signed two's complement
//   DEPTH   169  samples per frame (13x13)
//   ADDR_W  8    pointer width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high
//   in_data     in   DATA_W  feature-map sample from the pooling stage
//   in_valid    in   1       in_data valid this cycle; there is no ready (no backpressure)
//   out_data    out  DATA_W  sample at the read pointer
//   out_valid   out  1       out_data valid (high throughout DRAIN)
//   out_ready   in   1       downstream accepts; transfer = out_valid & out_ready
//   out_last    out  1       high with the sample at index DEPTH-1
//   frame_done  out  1       1-cycle pulse on the cycle after the DEPTH-th write
//   overflow    out  1       sticky; a sample was dropped because the buffer was full
//   wr_count    out  ADDR_W  samples captured in the current frame
// BEHAVIOUR
//   - Reset (async): state=FILL, wr_ptr=0, rd_ptr=0. All outputs 0: out_valid,
//     out_last, frame_done, overflow, wr_count=0, out_data=0. Buffer contents are
//     not cleared. Reset asserted mid-frame or mid-drain abandons the frame.
//   - Buffer: DEPTH x DATA_W array. 1 write port (clk). Combinational read at rd_ptr.
//   - FILL: each in_valid cycle writes mem[wr_ptr] and increments wr_ptr and wr_count.
//     On the write to index DEPTH-1 the state becomes DRAIN at that edge, and
//     frame_done pulses for exactly the next cycle.
//   - DRAIN: out_valid=1 and out_data=mem[rd_ptr]. out_last=(rd_ptr==DEPTH-1).
//     On a transfer rd_ptr increments. out_data/out_valid stay stable while
//     out_ready=0.
//   - End of DRAIN: the transfer with out_last moves the state to FILL with
//     rd_ptr=0, wr_ptr=0, wr_count=0. out_valid is low on the following cycle.
//   - Latency: the first out_valid is 1 cycle after the final input write
//     (it is coincident with frame_done). Minimum drain time is DEPTH cycles.
//   - in_valid during DRAIN: the sample is dropped, overflow is set (sticky until
//     reset), and the buffer and pointers are unchanged.
//   - Simultaneous event: in_valid on the same cycle as the out_last transfer is
//     accepted, not dropped. It is written to mem[0]; wr_ptr=1 and wr_count=1
//     afterwards; overflow is not set.
//   - Pointers never wrap past DEPTH-1. Indices >= DEPTH are unreachable.
//   - Samples are stored and replayed bit-exact, in arrival order.
//   - States: FILL -(write idx DEPTH-1)-> DRAIN -(transfer with out_last)-> FILL.
// CONFIGURATION
//   FMC_RELU_EN defined: a ReLU is applied at capture. If in_data[DATA_W-1]==1 the
//     stored value is 0; otherwise in_data is stored unchanged. Adds no cycles of
//     latency.
//   FMC_RELU_EN undefined: samples are stored unmodified, including negatives.
// TESTING
//   1. Reset, then drive 169 valid samples 0..168 back-to-back with out_ready=1.
//      -> frame_done pulses once; out_data streams 0..168; out_last only on 168;
//      -> overflow=0.
//   2. Fill as in (1), hold out_ready=0 for 20 cycles, then release.
//      -> out_valid=1 with out_data=0 held stable for all 20 cycles; then 0..168.
//   3. Drive 3 extra in_valid during DRAIN.
//      -> overflow=1 and stays 1; replay is unchanged; wr_count stays 169 until drained.
//   4. Assert in_valid=1 with in_data=16'h0055 on the out_last transfer cycle.
//      -> next frame has mem[0]=16'h0055, wr_count=1, overflow=0.
//   5. Assert reset after 50 writes, then send a full new frame.
//      -> all outputs 0 during reset; the new frame replays intact with no residue
//      -> from the old frame.
//   6. Input 16'hFF80 (-128) and 16'h007F (127).
//      -> FMC_RELU_EN undefined: replays FF80 and 007F.
//      -> FMC_RELU_EN defined: replays 0000 and 007F.

Source files
------------

// File: rtl/feature_map_collector.sv
// Feature-map frame buffer: captures one DEPTH-sample frame from the valid-only pooling
// stream, then replays it downstream over ready/valid with a last marker. Optional macro FMC_RELU_EN.
module feature_map_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 169,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0] wrCount_q, wrCount_d;
  logic              outValid_q, outValid_d;
  logic              outLast_q, outLast_d;
  logic              frameDone_q, frameDone_d;
  logic              overflow_q, overflow_d;

  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [DATA_W-1:0] memWdata;
  logic [ADDR_W-1:0] rdPtrInc;
  logic              xfer;

  logic [DATA_W-1:0] mem [DEPTH];

  // ReLU is folded into the capture path so it costs no extra cycle.
`ifdef FMC_RELU_EN
  assign memWdata = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign memWdata = in_data;
`endif

  assign xfer     = outValid_q & out_ready;
  assign rdPtrInc = rdPtr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    wrCount_d   = wrCount_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    frameDone_d = 1'b0;
    overflow_d  = overflow_q;
    memWe       = 1'b0;
    memWaddr    = wrPtr_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          memWe     = 1'b1;
          wrCount_d = wrCount_q + 1'b1;
          if (wrPtr_q == LAST_IDX) begin
            state_d     = DRAIN;
            wrPtr_d     = '0;
            frameDone_d = 1'b1;
            outValid_d  = 1'b1;
            outLast_d   = (rdPtr_q == LAST_IDX);
          end else begin
            wrPtr_d = wrPtr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // A sample arriving with the final transfer opens the next frame instead of being dropped.
        if (xfer && outLast_q) begin
          state_d    = FILL;
          rdPtr_d    = '0;
          outValid_d = 1'b0;
          outLast_d  = 1'b0;
          if (in_valid) begin
            memWe     = 1'b1;
            memWaddr  = '0;
            wrPtr_d   = ADDR_W'(1);
            wrCount_d = ADDR_W'(1);
          end else begin
            wrPtr_d   = '0;
            wrCount_d = '0;
          end
        end else begin
          if (in_valid) begin
            overflow_d = 1'b1;
          end
          if (xfer) begin
            rdPtr_d   = rdPtrInc;
            outLast_d = (rdPtrInc == LAST_IDX);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      wrCount_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      wrCount_q   <= wrCount_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      frameDone_q <= frameDone_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer contents deliberately survive reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  assign out_data   = outValid_q ? mem[rdPtr_q] : '0;
  assign out_valid  = outValid_q;
  assign out_last   = outLast_q;
  assign frame_done = frameDone_q;
  assign overflow   = overflow_q;
  assign wr_count   = wrCount_q;

endmodule

// File: tb/tb_feature_map_collector.sv
// Directed bench for feature_map_collector: fill/drain, backpressure, overflow,
// simultaneous last-transfer write, mid-frame reset and sign handling (FMC_RELU_EN aware).
module tb_feature_map_collector;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 169;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W-1:0] wr_count;

  int checkCount = 0;
  int errorCount = 0;

  logic [DATA_W-1:0] stim   [DEPTH];
  logic [DATA_W-1:0] expMem [DEPTH];

  feature_map_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
`ifdef FMC_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset wr_count", 32'(wr_count), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
  endtask

  // Drives stim[firstIdx..DEPTH-1] back-to-back and records the expected stored values.
  task automatic applyStimulus(input int firstIdx);
    int fdSeen;
    fdSeen = 0;
    for (int i = firstIdx; i < DEPTH; i++) begin
      in_valid  = 1'b1;
      in_data   = stim[i];
      expMem[i] = relu(stim[i]);
      step();
      if (frame_done) fdSeen++;
    end
    in_valid = 1'b0;
    checkOutput("frame_done after fill", 32'(fdSeen), 32'd1);
    checkOutput("out_valid after fill", 32'(out_valid), 32'd1);
    checkOutput("wr_count full", 32'(wr_count), 32'd169);
  endtask

  task automatic drainFrame(input bit lastWrite, input logic [DATA_W-1:0] lastData);
    for (int k = 0; k < DEPTH; k++) begin
      out_ready = 1'b1;
      checkOutput("drain out_valid", 32'(out_valid), 32'd1);
      checkOutput("drain out_data", 32'(out_data), 32'(expMem[k]));
      checkOutput("drain out_last", 32'(out_last), 32'(k == DEPTH - 1));
      if (k == DEPTH - 1 && lastWrite) begin
        in_valid = 1'b1;
        in_data  = lastData;
      end
      step();
      in_valid = 1'b0;
      if (k == 1) checkOutput("frame_done one cycle", 32'(frame_done), 32'd0);
    end
    out_ready = 1'b0;
    checkOutput("out_valid after drain", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    checkResetState();
    reset = 1'b0;

    // Test 1: plain frame 0..168 with downstream always ready.
    for (int i = 0; i < DEPTH; i++) stim[i] = 16'(i);
    applyStimulus(0);
    checkOutput("t1 first sample", 32'(out_data), 32'h0);
    drainFrame(1'b0, '0);
    checkOutput("t1 overflow", 32'(overflow), 32'd0);
    checkOutput("t1 wr_count cleared", 32'(wr_count), 32'd0);

    // Test 2: 20 cycles of backpressure hold the first sample.
    applyStimulus(0);
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checkOutput("t2 held valid", 32'(out_valid), 32'd1);
      checkOutput("t2 held data", 32'(out_data), 32'h0);
      step();
    end
    drainFrame(1'b0, '0);

    // Test 3: writes during drain are dropped and flag overflow.
    applyStimulus(0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 16'h7777;
      step();
    end
    in_valid = 1'b0;
    checkOutput("t3 overflow set", 32'(overflow), 32'd1);
    checkOutput("t3 wr_count held", 32'(wr_count), 32'd169);
    drainFrame(1'b0, '0);
    checkOutput("t3 overflow sticky", 32'(overflow), 32'd1);

    // Test 4: write coincident with the last transfer starts the next frame.
    reset = 1'b1;
    #1;
    checkResetState();
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) stim[i] = 16'(i) + 16'h0100;
    applyStimulus(0);
    drainFrame(1'b1, 16'h0055);
    checkOutput("t4 wr_count", 32'(wr_count), 32'd1);
    checkOutput("t4 overflow", 32'(overflow), 32'd0);
    checkOutput("t4 out_valid", 32'(out_valid), 32'd0);
    expMem[0] = 16'h0055;
    applyStimulus(1);
    checkOutput("t4 mem0", 32'(out_data), 32'h0055);
    drainFrame(1'b0, '0);

    // Test 5: reset after 50 writes, then a full fresh frame.
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i) + 16'h2000;
      step();
    end
    in_valid = 1'b0;
    checkOutput("t5 wr_count 50", 32'(wr_count), 32'd50);
    reset = 1'b1;
    #1;
    checkResetState();
    step();
    checkResetState();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) stim[i] = 16'(i * 3) + 16'h4000;
    applyStimulus(0);
    checkOutput("t5 first sample", 32'(out_data), 32'h4000);
    drainFrame(1'b0, '0);

    // Test 6: negative and positive extremes around the sign bit.
    for (int i = 0; i < DEPTH; i++) stim[i] = 16'(i);
    stim[0] = 16'hFF80;
    stim[1] = 16'h007F;
    applyStimulus(0);
`ifdef FMC_RELU_EN
    checkOutput("t6 negative sample", 32'(out_data), 32'h0000);
`else
    checkOutput("t6 negative sample", 32'(out_data), 32'hFF80);
`endif
    drainFrame(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
